// File: rtl/regfile.sv
// regfile: general-purpose integer register file for the MIPS pipeline.
//
// Two combinational read ports feed decode (execute-stage operands), one
// synchronous write port is driven by write-back. r0 is hard-wired to zero.
// A write-through bypass lets a read in the same cycle as a write to the
// same register see the new value, closing the write-back/decode RAW hazard.
//
// Ports:
//   clk            pipeline clock, rising-edge active
//   rst_n          asynchronous active-low reset, clears every register
//   we/waddr/wdata write request from write-back
//   stall          pipeline hold; suppresses the write (and the bypass)
//   re1/raddr1     read port 1 enable and index -> rdata1
//   re2/raddr2     read port 2 enable and index -> rdata2
//
// Optional feature (macro REGFILE_DBG_PORT_EN):
//   dbg_raddr      debug read index
//   dbg_rdata      registered debug read data (1-cycle latency, no bypass)
// With the macro undefined these ports and their logic are absent.

module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              stall
`ifdef REGFILE_DBG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
`endif
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_en;

  // A write only commits when not stalled and not aimed at r0; the same
  // qualifier gates the bypass so a suppressed write is never forwarded.
  assign wr_en = we && !stall && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (!rst_n || !re1 || (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (wr_en && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst_n || !re2 || (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (wr_en && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

`ifdef REGFILE_DBG_PORT_EN
  // Debug snapshot reads storage only; it deliberately ignores the bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata <= '0;
    end else if (dbg_raddr == '0) begin
      dbg_rdata <= '0;
    end else begin
      dbg_rdata <= regs[dbg_raddr];
    end
  end
`endif

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile.
// Expected values are queued when stimulus is driven and popped/compared
// once the design output has settled.

module tb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              stall;
`ifdef REGFILE_DBG_PORT_EN
  logic [ADDR_W-1:0] dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;
`endif

  int checks;
  int failures;

  string             tag_q [$];
  int                port_q [$];
  logic [DATA_W-1:0] val_q [$];

  regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .stall  (stall)
`ifdef REGFILE_DBG_PORT_EN
    ,
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every functional input at once.
  task automatic applyStimulus(input logic w_en, input logic [ADDR_W-1:0] w_a,
                               input logic [DATA_W-1:0] w_d,
                               input logic r1_en, input logic [ADDR_W-1:0] r1_a,
                               input logic r2_en, input logic [ADDR_W-1:0] r2_a,
                               input logic stl);
    we     = w_en;
    waddr  = w_a;
    wdata  = w_d;
    re1    = r1_en;
    raddr1 = r1_a;
    re2    = r2_en;
    raddr2 = r2_a;
    stall  = stl;
  endtask

  // Queue an expected value for port 1, 2 or 3 (debug).
  task automatic expectValue(input string tag, input int port,
                             input logic [DATA_W-1:0] value);
    tag_q.push_back(tag);
    port_q.push_back(port);
    val_q.push_back(value);
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic checkOutput();
    string             tag;
    int                port;
    logic [DATA_W-1:0] exp_v;
    logic [DATA_W-1:0] obs_v;
    #1;
    while (tag_q.size() > 0) begin
      tag   = tag_q.pop_front();
      port  = port_q.pop_front();
      exp_v = val_q.pop_front();
      obs_v = 'x;
      if (port == 1) obs_v = rdata1;
      else if (port == 2) obs_v = rdata2;
`ifdef REGFILE_DBG_PORT_EN
      else if (port == 3) obs_v = dbg_rdata;
`endif
      checks++;
      assert (obs_v === exp_v)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs_v, exp_v);
      end
    end
  endtask

  // Advance past a rising edge so inputs change well away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
`ifdef REGFILE_DBG_PORT_EN
    dbg_raddr = '0;
`endif
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0);
    expectValue("reset_rd1", 1, 32'h0);
    expectValue("reset_rd2", 2, 32'h0);
    checkOutput();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset clears a written register immediately, between edges.
    applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    expectValue("r5_written", 1, 32'h1234_5678);
    checkOutput();
    rst_n = 1'b0;
    expectValue("async_reset_rd", 1, 32'h0);
    checkOutput();
    tick();
    rst_n = 1'b1;
    expectValue("post_reset_rd", 1, 32'h0);
    checkOutput();

    // Basic write then read; disabled port reads zero.
    applyStimulus(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0);
    expectValue("basic_rd1", 1, 32'hDEAD_BEEF);
    expectValue("basic_rd2", 2, 32'hDEAD_BEEF);
    checkOutput();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0);
    expectValue("re1_off", 1, 32'h0);
    checkOutput();

    // r0 protection, same cycle and after the edge.
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    expectValue("r0_bypass_rd2", 2, 32'h0);
    expectValue("r0_bypass_rd1", 1, 32'h0);
    checkOutput();
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    expectValue("r0_stored", 2, 32'h0);
    checkOutput();

    // Bypass on both ports, then the same value from storage.
    applyStimulus(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
    expectValue("r7_old", 1, 32'h11);
    checkOutput();
    applyStimulus(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
    expectValue("bypass_rd1", 1, 32'h22);
    expectValue("bypass_rd2", 2, 32'h22);
    checkOutput();
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
    expectValue("bypass_stored1", 1, 32'h22);
    expectValue("bypass_stored2", 2, 32'h22);
    checkOutput();

    // Read and write to different addresses are independent.
    applyStimulus(1'b1, 5'd10, 32'h77, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0);
    expectValue("indep_rd1", 1, 32'hDEAD_BEEF);
    expectValue("indep_rd2", 2, 32'h22);
    checkOutput();
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0);
    expectValue("r10_stored", 1, 32'h77);
    checkOutput();

    // Stall suppresses both the write and the bypass.
    applyStimulus(1'b1, 5'd9, 32'hA, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd9, 32'hB, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1);
    expectValue("stall_nobypass", 1, 32'hA);
    checkOutput();
    tick();
    expectValue("stall_edge1", 1, 32'hA);
    checkOutput();
    tick();
    expectValue("stall_edge2", 1, 32'hA);
    checkOutput();
    stall = 1'b0;
    expectValue("unstall_bypass", 1, 32'hB);
    checkOutput();
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
    expectValue("unstall_stored", 1, 32'hB);
    checkOutput();

    // Write in flight while reset falls is lost.
    applyStimulus(1'b1, 5'd12, 32'h99, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd9, 1'b0);
    expectValue("lost_write_r12", 1, 32'h0);
    expectValue("reset_cleared_r9", 2, 32'h0);
    checkOutput();

`ifdef REGFILE_DBG_PORT_EN
    // Debug port: registered, one edge of latency, r0 reads zero.
    applyStimulus(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    dbg_raddr = 5'd4;
    expectValue("dbg_not_before", 3, 32'h0);
    checkOutput();
    tick();
    expectValue("dbg_r4", 3, 32'h55);
    checkOutput();
    dbg_raddr = 5'd0;
    tick();
    expectValue("dbg_r0", 3, 32'h0);
    checkOutput();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
